// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin request collector: error bit positions,
// per-slot status struct and index-width helper.
package rr_pkg;

    localparam int unsigned ERR_DROP      = 0;
    localparam int unsigned ERR_BAD_GRANT = 1;

    typedef struct packed {
        logic full;
        logic req;
        logic starve;
    } slot_status_t;

    // Index width for n clients; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_req_slot.sv
// One client slot: saturating outstanding-request counter, wait counter and
// full/starve status.
module rr_req_slot
    import rr_pkg::*;
#(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned WAIT_W   = 16,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              grant_i,   // qualified grant event: only high when count != 0
    output slot_status_t      status_o,
    output logic [WAIT_W-1:0] wait_o,
    output logic              drop_o
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              full;
    logic              pending;

    always_comb begin
        full    = (cnt_q == {CNT_W{1'b1}});
        pending = (cnt_q != '0);
        cnt_d   = cnt_q;
        drop_o  = 1'b0;
        wait_d  = wait_q;

        // Request and grant together cancel, which also admits a request at full.
        if (req_i && !grant_i) begin
            if (full) begin
                drop_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!req_i && grant_i) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (!pending || grant_i) begin
            wait_d = '0;
        end else if (wait_q != {WAIT_W{1'b1}}) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            wait_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
        end
    end

    assign status_o.full   = full;
    assign status_o.req    = pending;
    assign status_o.starve = (wait_q >= WAIT_W'(MAX_WAIT));
    assign wait_o          = wait_q;

endmodule

// File: rtl/rr_req_collector.sv
// Request-side front end for rr_top: per-client request counters, grant decode,
// acknowledge generation and starvation/high-water monitoring.
module rr_req_collector
    import rr_pkg::*;
#(
    parameter int unsigned REQCNT   = 16,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned WAIT_W   = 16,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [REQCNT-1:0]          cli_req_i,
    output logic [REQCNT-1:0]          cli_full_o,
    output logic [REQCNT-1:0]          arb_req_o,
    output logic                       arb_req_val_o,
    input  logic [idx_w(REQCNT)-1:0]   arb_num_i,
    input  logic                       arb_num_val_i,
    output logic [REQCNT-1:0]          cli_ack_o,
    output logic [REQCNT-1:0]          starve_o,
    output logic [WAIT_W-1:0]          max_wait_o,
    output logic [1:0]                 err_o
);

    localparam int unsigned IDX_W = idx_w(REQCNT);

    slot_status_t      status   [REQCNT];
    logic [WAIT_W-1:0] wait_cnt [REQCNT];
    logic [REQCNT-1:0] grant_ev;
    logic [REQCNT-1:0] drop;

    logic [REQCNT-1:0] ack_q;
    logic [WAIT_W-1:0] max_wait_q, max_wait_d;
    logic [1:0]        err_q, err_d;
    logic              bad_grant;

    for (genvar i = 0; i < REQCNT; i++) begin : g_slot
        rr_req_slot #(
            .CNT_W    (CNT_W),
            .WAIT_W   (WAIT_W),
            .MAX_WAIT (MAX_WAIT)
        ) u_slot (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .req_i    (cli_req_i[i]),
            .grant_i  (grant_ev[i]),
            .status_o (status[i]),
            .wait_o   (wait_cnt[i]),
            .drop_o   (drop[i])
        );
    end

    // An out-of-range index matches no slot, so it falls into the bad-grant case.
    always_comb begin
        for (int i = 0; i < REQCNT; i++) begin
            arb_req_o[i]  = status[i].req;
            cli_full_o[i] = status[i].full;
            starve_o[i]   = status[i].starve;
            grant_ev[i]   = arb_num_val_i && (arb_num_i == IDX_W'(i)) && status[i].req;
        end
    end

    assign arb_req_val_o = |arb_req_o;
    assign bad_grant     = arb_num_val_i && !(|grant_ev);

    always_comb begin
        err_d                = err_q;
        err_d[ERR_DROP]      = err_q[ERR_DROP] | (|drop);
        err_d[ERR_BAD_GRANT] = err_q[ERR_BAD_GRANT] | bad_grant;

        max_wait_d = max_wait_q;
        for (int i = 0; i < REQCNT; i++) begin
            if (wait_cnt[i] > max_wait_d) begin
                max_wait_d = wait_cnt[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q      <= '0;
            max_wait_q <= '0;
            err_q      <= '0;
        end else begin
            ack_q      <= grant_ev;
            max_wait_q <= max_wait_d;
            err_q      <= err_d;
        end
    end

    assign cli_ack_o  = ack_q;
    assign max_wait_o = max_wait_q;
    assign err_o      = err_q;

endmodule
